// File: rtl/jtag_scan_master.sv
// JTAG scan master: turns TAP-reset / IR-shift / DR-shift / idle commands into
// a TCK/TMS/TDI waveform from the system clock and returns the captured TDO bits.
module jtag_scan_master #(
    parameter int MAXLEN = 32,
    parameter int CLKDIV = 2,
    parameter int LW     = $clog2(MAXLEN + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LW-1:0]     cmd_len,
    input  logic [MAXLEN-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MAXLEN-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
);
    localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam int CW = $clog2(2 * CLKDIV);
    localparam logic [CW-1:0] HI_START = CW'(CLKDIV);
    localparam logic [CW-1:0] CNT_TOP  = CW'(2 * CLKDIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]        state_reg;
    logic [1:0]        op_reg;
    logic [LW-1:0]     len_reg;
    logic [MAXLEN-1:0] data_reg;
    logic [LW-1:0]     step_reg;
    logic [LW-1:0]     pre_last_reg;
    logic              last_reg;
    logic [CW-1:0]     cnt_reg;
    logic              cap_en_reg;
    logic [IW-1:0]     cap_idx_reg;
    logic              tap_known_reg;
    logic              tck_reg, tms_reg, tdi_reg, busy_reg;
    logic [MAXLEN-1:0] rsp_data_reg;
    logic              rsp_err_reg;

    logic          is_shift_cmd, reject, empty_idle;
    logic [LW-1:0] pre_last_init;
    logic          emit_tms, emit_tdi, emit_shift;
    logic [2:0]    state_next;
    logic [LW-1:0] step_next;
    logic          last_next;

    assign is_shift_cmd = (cmd_op == 2'b01) || (cmd_op == 2'b10);
    assign reject       = is_shift_cmd &&
                          ((cmd_len == '0) || (cmd_len > LW'(MAXLEN)) || !tap_known_reg);
    assign empty_idle   = (cmd_op == 2'b11) && (cmd_len == '0);

    // PRE covers the leading TMS walk; idle commands spend all their cycles there.
    always_comb begin
        pre_last_init = '0;
        case (cmd_op)
            2'b00:   pre_last_init = LW'(5);
            2'b01:   pre_last_init = LW'(3);
            2'b10:   pre_last_init = LW'(2);
            default: pre_last_init = cmd_len - LW'(1);
        endcase
    end

    // Values for the TCK cycle about to start, and the pointer to the one after it.
    always_comb begin
        emit_tms   = 1'b0;
        emit_tdi   = 1'b0;
        emit_shift = 1'b0;
        state_next = state_reg;
        step_next  = step_reg + LW'(1);
        last_next  = 1'b0;
        case (state_reg)
            S_PRE: begin
                case (op_reg)
                    2'b00:   emit_tms = (step_reg < LW'(5));
                    2'b01:   emit_tms = (step_reg < LW'(2));
                    2'b10:   emit_tms = (step_reg == '0);
                    default: emit_tms = 1'b0;
                endcase
                if (step_reg == pre_last_reg) begin
                    if (op_reg == 2'b01 || op_reg == 2'b10) begin
                        state_next = S_SHIFT;
                        step_next  = '0;
                    end else begin
                        last_next = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                emit_tms   = (step_reg == len_reg - LW'(1));
                emit_tdi   = data_reg[step_reg[IW-1:0]];
                emit_shift = 1'b1;
                if (step_reg == len_reg - LW'(1)) begin
                    state_next = S_POST;
                    step_next  = '0;
                end
            end
            S_POST: begin
                emit_tms = (step_reg == '0);
                if (step_reg == LW'(1)) begin
                    last_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            op_reg        <= '0;
            len_reg       <= '0;
            data_reg      <= '0;
            step_reg      <= '0;
            pre_last_reg  <= '0;
            last_reg      <= 1'b0;
            cnt_reg       <= '0;
            cap_en_reg    <= 1'b0;
            cap_idx_reg   <= '0;
            tap_known_reg <= 1'b0;
            tck_reg       <= 1'b0;
            tms_reg       <= 1'b0;
            tdi_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_reg       <= cmd_op;
                        len_reg      <= cmd_len;
                        data_reg     <= cmd_data;
                        rsp_data_reg <= '0;
                        rsp_err_reg  <= reject;
                        step_reg     <= '0;
                        pre_last_reg <= pre_last_init;
                        last_reg     <= reject || empty_idle;
                        cnt_reg      <= '0;
                        cap_en_reg   <= 1'b0;
                        state_reg    <= S_PRE;
                    end
                end
                S_PRE, S_SHIFT, S_POST: begin
                    if (cnt_reg == '0) begin
                        tck_reg <= 1'b0;
                        if (last_reg) begin
                            state_reg <= S_RESP;
                            tms_reg   <= 1'b0;
                            tdi_reg   <= 1'b0;
                            busy_reg  <= 1'b0;
                            if (op_reg == 2'b00) begin
                                tap_known_reg <= 1'b1;
                            end
                        end else begin
                            tms_reg     <= emit_tms;
                            tdi_reg     <= emit_tdi;
                            cap_en_reg  <= emit_shift;
                            cap_idx_reg <= step_reg[IW-1:0];
                            state_reg   <= state_next;
                            step_reg    <= step_next;
                            last_reg    <= last_next;
                            busy_reg    <= 1'b1;
                            cnt_reg     <= cnt_reg + CW'(1);
                        end
                    end else begin
                        // TDO is captured on the same clock that raises TCK.
                        if (cnt_reg == HI_START) begin
                            tck_reg <= 1'b1;
                            if (cap_en_reg) begin
                                rsp_data_reg[cap_idx_reg] <= TDO;
                            end
                        end
                        cnt_reg <= (cnt_reg == CNT_TOP) ? '0 : cnt_reg + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = busy_reg;
    assign TCK       = tck_reg;
    assign TMS       = tms_reg;
    assign TDI       = tdi_reg;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Scoreboard bench for jtag_scan_master driving a behavioural TAP whose DR is
// the one-bit BYPASS register; responses are checked by a decoupled monitor.
module tb_jtag_scan_master;
    localparam int MAXLEN = 32;
    localparam int CLKDIV = 2;
    localparam int LW     = $clog2(MAXLEN + 1);

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [LW-1:0]     cmd_len = '0;
    logic [MAXLEN-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [MAXLEN-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              TCK, TMS, TDI;
    logic              TDO = 1'b0;

    always #5 CLK = ~CLK;

    jtag_scan_master #(.MAXLEN(MAXLEN), .CLKDIV(CLKDIV), .LW(LW)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    // Behavioural TAP controller; IR capture value is 2'b01.
    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
    localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
    int       tap_st = PDR;
    logic [1:0] ir_sr = 2'b00;
    logic     byp = 1'b0;

    always @(posedge TCK) begin
        case (tap_st)
            CIR:  ir_sr = 2'b01;
            SHIR: ir_sr = {TDI, ir_sr[1]};
            CDR:  byp = 1'b0;
            SHDR: byp = TDI;
            default: ;
        endcase
        case (tap_st)
            TLR:  tap_st = TMS ? TLR  : RTI;
            RTI:  tap_st = TMS ? SDR  : RTI;
            SDR:  tap_st = TMS ? SIR  : CDR;
            CDR:  tap_st = TMS ? E1DR : SHDR;
            SHDR: tap_st = TMS ? E1DR : SHDR;
            E1DR: tap_st = TMS ? UDR  : PDR;
            PDR:  tap_st = TMS ? E2DR : PDR;
            E2DR: tap_st = TMS ? UDR  : SHDR;
            UDR:  tap_st = TMS ? SDR  : RTI;
            SIR:  tap_st = TMS ? TLR  : CIR;
            CIR:  tap_st = TMS ? E1IR : SHIR;
            SHIR: tap_st = TMS ? E1IR : SHIR;
            E1IR: tap_st = TMS ? UIR  : PIR;
            PIR:  tap_st = TMS ? E2IR : PIR;
            E2IR: tap_st = TMS ? UIR  : SHIR;
            default: tap_st = TMS ? SDR : RTI;
        endcase
    end

    always @(negedge TCK) begin
        TDO = (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? byp : 1'b0;
    end

    int   edge_no = 0;
    int   tck_total = 0;
    logic tms_hist [0:1023];
    logic tdi_hist [0:1023];

    always @(posedge CLK) edge_no++;

    always @(posedge TCK) begin
        if (tck_total < 1024) begin
            tms_hist[tck_total] = TMS;
            tdi_hist[tck_total] = TDI;
        end
        tck_total++;
    end

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          ntck;
        logic [63:0] tms;
        logic [63:0] tdi;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] d, input logic e,
                              input int lat, input int ntck,
                              input logic [63:0] tms, input logic [63:0] tdi);
        exp_t x;
        x.name = name; x.data = d; x.err = e; x.lat = lat;
        x.ntck = ntck; x.tms = tms; x.tdi = tdi;
        sb.push_back(x);
    endtask

    // Monitor: measures latency/TCK activity per command and pops the scoreboard.
    int          acc_edge = 0, acc_tck = 0, lat_seen = 0;
    bit          rsp_seen = 0, unstable = 0, ready_bad = 0;
    logic [31:0] held_data;
    logic        held_err;

    always @(negedge CLK) begin
        if (RST) begin
            rsp_seen = 0; unstable = 0; ready_bad = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                acc_edge = edge_no + 1;
                acc_tck  = tck_total;
            end
            if (rsp_valid) begin
                if (!rsp_seen) begin
                    rsp_seen  = 1;
                    lat_seen  = edge_no - acc_edge;
                    held_data = rsp_data;
                    held_err  = rsp_err;
                end else if (rsp_data !== held_data || rsp_err !== held_err) begin
                    unstable = 1;
                end
                if (cmd_ready) ready_bad = 1;
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_rsp: got data %0h err %0b, want no response", rsp_data, rsp_err);
                    end else begin
                        exp_t x;
                        int n;
                        logic [63:0] got_tms, got_tdi;
                        x = sb.pop_front();
                        n = tck_total - acc_tck;
                        got_tms = '0;
                        got_tdi = '0;
                        for (int i = 0; i < n && i < 64; i++) begin
                            got_tms[i] = tms_hist[acc_tck + i];
                            got_tdi[i] = tdi_hist[acc_tck + i];
                        end
                        $display("txn %s: data=%h err=%0b lat=%0d tck=%0d tms=%0h tdi=%0h",
                                 x.name, rsp_data, rsp_err, lat_seen, n, got_tms, got_tdi);
                        check({x.name, ".data"}, {32'd0, rsp_data}, {32'd0, x.data});
                        check({x.name, ".err"}, {63'd0, rsp_err}, {63'd0, x.err});
                        check({x.name, ".latency"}, lat_seen, x.lat);
                        check({x.name, ".tck_cycles"}, n, x.ntck);
                        check({x.name, ".tms"}, got_tms, x.tms);
                        check({x.name, ".tdi"}, got_tdi, x.tdi);
                        check({x.name, ".rsp_stable"}, {63'd0, unstable}, 64'd0);
                        check({x.name, ".cmd_ready_low"}, {63'd0, ready_bad}, 64'd0);
                    end
                    rsp_seen = 0; unstable = 0; ready_bad = 0;
                end
            end
        end
    end

    task automatic timeout_fail(input string name);
        checks++;
        $display("FAIL %s: got timeout, want event within bound", name);
    endtask

    task automatic hold_until_accept(input string name);
        int t = 0;
        while (!cmd_ready && t < 500) begin
            @(posedge CLK); #1; t++;
        end
        if (!cmd_ready) timeout_fail({name, ".accept"});
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input string name, input logic [1:0] op, input logic [LW-1:0] len,
                        input logic [31:0] data);
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        hold_until_accept(name);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!(sb.size() == 0 && cmd_ready && !rsp_valid) && t < 1000) begin
            @(posedge CLK); #1; t++;
        end
        if (t >= 1000) timeout_fail({name, ".done"});
        check({name, ".pins_idle"}, {61'd0, TCK, TMS, TDI}, 64'd0);
    endtask

    initial begin
        int t;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset.cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("reset.rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset.rsp_data",  {32'd0, rsp_data}, 64'd0);
        check("reset.rsp_err",   {63'd0, rsp_err}, 64'd0);
        check("reset.busy",      {63'd0, busy}, 64'd0);
        check("reset.pins",      {61'd0, TCK, TMS, TDI}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        expect_rsp("dr_tap_unknown", 32'h0, 1'b1, 1, 0, 64'h0, 64'h0);
        send("dr_tap_unknown", 2'b10, 6'd8, 32'hA5);
        wait_done("dr_tap_unknown");

        expect_rsp("tap_reset", 32'h0, 1'b0, 25, 6, 64'h1F, 64'h0);
        send("tap_reset", 2'b00, 6'd5, 32'hDEAD_BEEF);
        wait_done("tap_reset");

        expect_rsp("ir_bypass", 32'h1, 1'b0, 33, 8, 64'h63, 64'h30);
        send("ir_bypass", 2'b01, 6'd2, 32'h3);
        wait_done("ir_bypass");

        // Backpressure with a queued idle-len-0 command waiting on cmd_ready.
        rsp_ready = 1'b0;
        expect_rsp("dr_bypass_bp", 32'h4A, 1'b0, 53, 13, 64'hC01, 64'h528);
        send("dr_bypass_bp", 2'b10, 6'd8, 32'hA5);
        expect_rsp("idle0_after_bp", 32'h0, 1'b0, 1, 0, 64'h0, 64'h0);
        cmd_op = 2'b11; cmd_len = 6'd0; cmd_data = 32'h0; cmd_valid = 1'b1;
        t = 0;
        while (!rsp_valid && t < 500) begin
            @(posedge CLK); #1; t++;
        end
        if (!rsp_valid) timeout_fail("dr_bypass_bp.rsp");
        repeat (10) @(posedge CLK);
        #1;
        rsp_ready = 1'b1;
        hold_until_accept("idle0_after_bp");
        wait_done("dr_bypass_bp");

        expect_rsp("dr_len0", 32'h0, 1'b1, 1, 0, 64'h0, 64'h0);
        send("dr_len0", 2'b10, 6'd0, 32'hFF);
        wait_done("dr_len0");

        expect_rsp("dr_len33", 32'h0, 1'b1, 1, 0, 64'h0, 64'h0);
        send("dr_len33", 2'b10, 6'd33, 32'hFF);
        wait_done("dr_len33");

        expect_rsp("dr_len32", 32'hFFFF_FFFE, 1'b0, 149, 37,
                   64'h0000_000C_0000_0001, 64'h0000_0007_FFFF_FFF8);
        send("dr_len32", 2'b10, 6'd32, 32'hFFFF_FFFF);
        wait_done("dr_len32");

        expect_rsp("idle0", 32'h0, 1'b0, 1, 0, 64'h0, 64'h0);
        send("idle0", 2'b11, 6'd0, 32'hFF);
        wait_done("idle0");

        expect_rsp("idle3", 32'h0, 1'b0, 13, 3, 64'h0, 64'h0);
        send("idle3", 2'b11, 6'd3, 32'hFF);
        wait_done("idle3");

        // Reset in the middle of a len-16 DR shift: no response is expected.
        send("dr16_abort", 2'b10, 6'd16, 32'h1234);
        t = 0;
        while ((tck_total - acc_tck) < 6 && t < 500) begin
            @(posedge CLK); #1; t++;
        end
        if (t >= 500) timeout_fail("dr16_abort.shift");
        check("dr16_abort.busy_mid", {63'd0, busy}, 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("dr16_abort.tck",       {63'd0, TCK}, 64'd0);
        check("dr16_abort.busy",      {63'd0, busy}, 64'd0);
        check("dr16_abort.rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("dr16_abort.cmd_ready", {63'd0, cmd_ready}, 64'd1);
        RST = 1'b0;
        @(posedge CLK); #1;

        expect_rsp("dr_after_rst", 32'h0, 1'b1, 1, 0, 64'h0, 64'h0);
        send("dr_after_rst", 2'b10, 6'd8, 32'hA5);
        wait_done("dr_after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

- Sequences the boundary-scan test access port from a single system clock.
- Accepts simple scan commands: TAP reset, instruction-register shift, data-register shift, idle clocks.
- For each command it generates the TCK/TMS/TDI waveform, captures TDO, and returns the captured bits on a response handshake.
- Sits between an on-chip test host (CPU or BIST sequencer) and the JTAG top's TDI/TMS/TCK/TDO pins.

## Interface
- MAXLEN, 32, maximum shift length in bits.
- CLKDIV, 2, CLK cycles per TCK half-period (≥1).
- LW, $clog2(MAXLEN+1), width of cmd_len.
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  input  2  00 TAP reset, 01 IR shift, 10 DR shift, 11 idle.
- cmd_len  input  LW  shift length (ops 01/10) or idle TCK count (op 11); ignored for op 00.
- cmd_data  input  MAXLEN  TDI bits, bit 0 shifted first.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  output  MAXLEN  captured TDO bits, bit 0 captured first, bits ≥ len are 0.
- rsp_err  output  1  command rejected; no TCK activity occurred.
- busy  output  1  command in progress (accepted, response not yet issued).
- TCK  output  1  test clock.
- TMS  output  1  test mode select.
- TDI  output  1  test data in.
- TDO  input  1  test data out from the TAP; changes on falling TCK.

## Operation
- FSM states: IDLE, PRE, SHIFT, POST, RESP.
- Accept: only in IDLE with rsp_valid=0.
  - Latch op, len, data.
  - Evaluate rejection:
    - op 01/10 with len==0 → RESP, rsp_err=1.
    - op 01/10 with len>MAXLEN → RESP, rsp_err=1.
    - op 01/10 while tap_known=0 → RESP, rsp_err=1.
  - Otherwise go to PRE.
- tap_known:
  - Cleared by RST.
  - Set on completion of op 00.
- Per-op TMS sequence, one value per TCK cycle:
  - op 00 (reset): 1,1,1,1,1,0. 6 cycles, ends in Run-Test/Idle.
  - op 01 (IR shift):
    - PRE: 1,1,0,0.
    - SHIFT: len cycles, TMS=0 except last =1.
    - POST: 1,0.
    - Total len+6.
  - op 10 (DR shift):
    - PRE: 1,0,0.
    - SHIFT: len cycles as above.
    - POST: 1,0.
    - Total len+5.
  - op 11 (idle): len cycles of TMS=0. len==0 → RESP immediately, no TCK, rsp_err=0.
- SHIFT cycle k (0..len-1):
  - TDI=data[k].
  - TDO sampled into rsp_data[k].
- Outside SHIFT: TDI=0.
- Ops 00 and 11 return rsp_data=0.
- RESP:
  - rsp_valid=1.
  - rsp_data and rsp_err held stable until rsp_ready.
  - Then return to IDLE.
- rsp_data is cleared at each accept.

## Timing
- TCK cycle = 2·CLKDIV CLK cycles: low phase CLKDIV, then high phase CLKDIV.
- TMS/TDI change only at the CLK edge that starts a low phase, i.e. on falling TCK.
- TDO is sampled at the CLK edge that drives TCK 0→1.
- Accept at edge e:
  - First low phase (TCK=0, TMS/TDI valid) begins at edge e+1.
  - busy=1 from e+1.
- Command of T TCK cycles occupies CLK edges e+1 .. e+2·CLKDIV·T.
- rsp_valid=1 from edge e+2·CLKDIV·T+1, with TCK already low.
- Rejected command, or op 11 with len 0: rsp_valid=1 at e+1. No TCK edge.
- Between commands:
  - TCK=0, TMS=0, TDI=0.
  - No TCK toggling.
- cmd_ready=0 from accept until the rsp handshake completes.
- Earliest next accept is the cycle after rsp handshake.
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, TCK=0, TMS=0, TDI=0, FSM=IDLE, tap_known=0.
- RST mid-command:
  - All outputs at reset values at the next edge.
  - Command and response discarded.
  - tap_known=0.

## Test plan
- RST, then DR shift len 8 → rsp_err=1 at accept+1; TCK stays 0 throughout.
- TAP reset, CLKDIV=2 → TMS 1,1,1,1,1,0 on 6 TCK periods of 4 CLK each; rsp_valid at accept+25; rsp_data=0, rsp_err=0.
- Against JTAG top N=16: IR shift len 2 data 2'b11 (BYPASS) → TMS 1,1,0,0,0,1,1,0; TDI 1,1 in SHIFT. Then DR shift len 8 data 8'hA5 → rsp_data=8'h4A (bypass bit captures 0, one-bit delay).
- Backpressure: hold rsp_ready=0 for 10 cycles with cmd_valid=1 → rsp_valid, rsp_data, rsp_err stable; cmd_ready=0; no new TCK activity.
- Length boundaries:
  - DR len 0 → err.
  - DR len 33 → err.
  - DR len 32 data 32'hFFFFFFFF → 37 TCK periods, rsp_err=0.
  - Idle len 0 → rsp at accept+1, rsp_err=0.
- Assert RST during SHIFT of a len-16 DR → next edge TCK=0, busy=0, rsp_valid=0; subsequent DR shift → rsp_err=1.
